// File: rtl/svm_mc_engine.sv
// Multi-class sequential SVM engine: N_CLASS binary classifiers over a shared support-vector store.
// Optional: define SVM_SCORE_OUT_EN to add the per-class scores output.
module svm_mc_engine #(
  parameter int NBITS       = 9,
  parameter int F_WIDTH     = 214,
  parameter int LOG_F_WIDTH = 8,
  parameter int NSUP        = 155,
  parameter int LOG_NSUP    = 8,
  parameter int N_CLASS     = 2,
  parameter int LOG_N_CLASS = 1,
  parameter int ACC_W       = 3*NBITS+LOG_F_WIDTH+LOG_NSUP+1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mem_we,
  input  logic [LOG_N_CLASS-1:0]           mem_class,
  input  logic [LOG_NSUP-1:0]              mem_write_addr,
  input  logic [NBITS*F_WIDTH-1:0]         in_support,
  input  logic [NBITS-1:0]                 in_alpha,
  input  logic                             intercept_valid,
  input  logic [N_CLASS*ACC_W-1:0]         in_intercept,
  input  logic [N_CLASS*(LOG_NSUP+1)-1:0]  in_nsup,
  output logic                             mem_write_ready,
  input  logic                             mem_write_done,
  input  logic [NBITS*F_WIDTH-1:0]         in_features,
  input  logic                             fin_valid,
  output logic                             fin_ready,
  output logic [N_CLASS-1:0]               labels,
  output logic                             dout_valid,
  input  logic                             dout_ready
`ifdef SVM_SCORE_OUT_EN
  ,
  output logic [N_CLASS*ACC_W-1:0]         scores
`endif
);

  localparam int DOT_W  = 2*NBITS+LOG_F_WIDTH;
  localparam int PROD_W = DOT_W+NBITS;
  localparam int NS_W   = LOG_NSUP+1;

  typedef enum logic [2:0] {LOAD_WAIT, LOAD, READY, COMPUTE, OUT} state_t;
  state_t state, state_next;

  logic [NBITS*F_WIDTH-1:0] sv_mem    [N_CLASS][NSUP];
  logic signed [NBITS-1:0]  alpha_mem [N_CLASS][NSUP];
  logic signed [ACC_W-1:0]  icpt      [N_CLASS];
  logic [NS_W-1:0]          nsup_r    [N_CLASS];

  logic [LOG_N_CLASS-1:0]   cls;
  logic [LOG_NSUP-1:0]      s;
  logic signed [ACC_W-1:0]  acc, acc_next, acc_fin;
  logic [NBITS*F_WIDTH-1:0] feat;
  logic signed [DOT_W-1:0]  dot;
  logic signed [PROD_W-1:0] prod;
  logic [NS_W-1:0]          nsup_cur;
  logic                     sv_empty, sv_last, cls_last;

  function automatic logic signed [DOT_W-1:0] dot_fn(input logic [NBITS*F_WIDTH-1:0] a,
                                                     input logic [NBITS*F_WIDTH-1:0] b);
    logic signed [DOT_W-1:0]   sum;
    logic signed [NBITS-1:0]   x, y;
    logic signed [2*NBITS-1:0] p;
    sum = '0;
    for (int unsigned j = 0; j < F_WIDTH; j++) begin
      x   = a[j*NBITS +: NBITS];
      y   = b[j*NBITS +: NBITS];
      p   = x * y;
      sum = sum + DOT_W'(p);
    end
    return sum;
  endfunction

  assign nsup_cur = nsup_r[cls];
  assign sv_empty = (nsup_cur == '0);
  assign sv_last  = sv_empty || (NS_W'(s) == nsup_cur - NS_W'(1));
  assign cls_last = (32'(cls) == N_CLASS-1);

  always_comb begin
    dot      = dot_fn(sv_mem[cls][s], feat);
    prod     = alpha_mem[cls][s] * dot;
    acc_next = acc + ACC_W'(prod);
    acc_fin  = sv_empty ? acc : acc_next;
  end

  always_comb begin
    state_next      = state;
    mem_write_ready = 1'b0;
    fin_ready       = 1'b0;
    dout_valid      = 1'b0;
    unique case (state)
      LOAD_WAIT: state_next = LOAD;
      LOAD: begin
        mem_write_ready = 1'b1;
        if (mem_write_done) state_next = READY;
      end
      READY: begin
        fin_ready = 1'b1;
        if (fin_valid) state_next = COMPUTE;
      end
      COMPUTE: if (sv_last) state_next = cls_last ? OUT : READY;
      OUT: begin
        dout_valid = 1'b1;
        if (dout_ready) state_next = READY;
      end
      default: state_next = LOAD_WAIT;
    endcase
  end

  // Store contents survive reset; only the FSM forces a reload.
  always_ff @(posedge clk) begin
    if (!rst && state == LOAD) begin
      if (!mem_we && 32'(mem_write_addr) < NSUP && 32'(mem_class) < N_CLASS) begin
        sv_mem[mem_class][mem_write_addr]    <= in_support;
        alpha_mem[mem_class][mem_write_addr] <= in_alpha;
      end
      if (intercept_valid) begin
        for (int unsigned c = 0; c < N_CLASS; c++) begin
          icpt[c]   <= in_intercept[c*ACC_W +: ACC_W];
          nsup_r[c] <= (32'(in_nsup[c*NS_W +: NS_W]) > NSUP) ? NS_W'(NSUP)
                                                             : in_nsup[c*NS_W +: NS_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD_WAIT;
      cls    <= '0;
      s      <= '0;
      acc    <= '0;
      feat   <= '0;
      labels <= '0;
`ifdef SVM_SCORE_OUT_EN
      scores <= '0;
`endif
    end else begin
      state <= state_next;
      unique case (state)
        READY: if (fin_valid) begin
          feat <= in_features;
          acc  <= icpt[cls];
          s    <= '0;
        end
        COMPUTE: begin
          if (!sv_empty) begin
            acc <= acc_next;
            s   <= s + LOG_NSUP'(1);
          end
          if (sv_last) begin
            labels[cls] <= ~acc_fin[ACC_W-1];
`ifdef SVM_SCORE_OUT_EN
            scores[32'(cls)*ACC_W +: ACC_W] <= acc_fin;
`endif
            if (!cls_last) cls <= cls + LOG_N_CLASS'(1);
          end
        end
        OUT: if (dout_ready) cls <= '0;
        default: cls <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_mc_engine.sv
// Directed self-checking bench for svm_mc_engine (F_WIDTH=4, NSUP=3, N_CLASS=2, NBITS=9).
module tb_svm_mc_engine;
  localparam int NBITS = 9, F_WIDTH = 4, LOG_F_WIDTH = 2, NSUP = 3, LOG_NSUP = 2;
  localparam int N_CLASS = 2, LOG_N_CLASS = 1;
  localparam int ACC_W = 3*NBITS+LOG_F_WIDTH+LOG_NSUP+1;

  logic clk, rst, mem_we, intercept_valid, mem_write_ready, mem_write_done;
  logic fin_valid, fin_ready, dout_valid, dout_ready;
  logic [LOG_N_CLASS-1:0]          mem_class;
  logic [LOG_NSUP-1:0]             mem_write_addr;
  logic [NBITS*F_WIDTH-1:0]        in_support, in_features;
  logic [NBITS-1:0]                in_alpha;
  logic [N_CLASS*ACC_W-1:0]        in_intercept;
  logic [N_CLASS*(LOG_NSUP+1)-1:0] in_nsup;
  logic [N_CLASS-1:0]              labels;
`ifdef SVM_SCORE_OUT_EN
  logic [N_CLASS*ACC_W-1:0]        scores;
`endif

  int checks = 0, errors = 0;

  svm_mc_engine #(.NBITS(NBITS), .F_WIDTH(F_WIDTH), .LOG_F_WIDTH(LOG_F_WIDTH), .NSUP(NSUP),
                  .LOG_NSUP(LOG_NSUP), .N_CLASS(N_CLASS), .LOG_N_CLASS(LOG_N_CLASS),
                  .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_class(mem_class),
    .mem_write_addr(mem_write_addr), .in_support(in_support), .in_alpha(in_alpha),
    .intercept_valid(intercept_valid), .in_intercept(in_intercept), .in_nsup(in_nsup),
    .mem_write_ready(mem_write_ready), .mem_write_done(mem_write_done),
    .in_features(in_features), .fin_valid(fin_valid), .fin_ready(fin_ready),
    .labels(labels), .dout_valid(dout_valid), .dout_ready(dout_ready)
`ifdef SVM_SCORE_OUT_EN
    , .scores(scores)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] pack4(input int a, input int b, input int c, input int d);
    return {d[8:0], c[8:0], b[8:0], a[8:0]};
  endfunction

  task automatic write_row(input int c, input int a, input logic [35:0] row, input int al);
    mem_class      = c[0:0];
    mem_write_addr = a[1:0];
    in_support     = row;
    in_alpha       = al[8:0];
    mem_we         = 1'b0;
    @(negedge clk);
    mem_we         = 1'b1;
  endtask

  task automatic set_params(input int i0, input int i1, input int n0, input int n1);
    in_intercept    = {i1, i0};
    in_nsup         = {n1[2:0], n0[2:0]};
    intercept_valid = 1'b1;
    @(negedge clk);
    intercept_valid = 1'b0;
  endtask

  task automatic finish_load(input string tag);
    mem_write_done = 1'b1;
    @(negedge clk);
    mem_write_done = 1'b0;
    check({tag, "_fin_ready"}, fin_ready, 1);
    check({tag, "_mwr_low"}, mem_write_ready, 0);
  endtask

  // lat counts cycles from the first handshake cycle to the first cycle with dout_valid.
  task automatic run_inf(input logic [35:0] xa, input logic [35:0] xb,
                         output int lat, output logic [1:0] frp);
    int cyc;
    in_features = xa;
    fin_valid   = 1'b1;
    cyc = 0;
    while (!fin_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    frp = '0;
    @(negedge clk);
    in_features = xb;
    lat    = 1;
    frp[0] = fin_ready;
    while (!dout_valid && lat < 50) begin
      @(negedge clk);
      lat++;
      if (lat == 2) frp[1] = fin_ready;
    end
    fin_valid = 1'b0;
  endtask

  initial begin
    logic [35:0] sv00, sv10, sv11, x0, x1, rowm;
    int lat;
    logic [1:0] frp;
    logic ok;

    sv00 = pack4(1, 2, 3, 4);
    sv10 = pack4(1, 0, 0, 0);
    sv11 = pack4(0, 1, 0, 0);
    x0   = pack4(1, 1, 1, 1);
    x1   = pack4(4, 5, 0, 0);
    rowm = pack4(-256, -256, -256, -256);

    rst = 1'b1; mem_we = 1'b1; mem_class = '0; mem_write_addr = '0; in_support = '0;
    in_alpha = '0; intercept_valid = 1'b0; in_intercept = '0; in_nsup = '0;
    mem_write_done = 1'b0; in_features = '0; fin_valid = 1'b0; dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mwr", mem_write_ready, 0);
    check("rst_fin_ready", fin_ready, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_labels", labels, 0);
    rst = 1'b0;
    check("load_wait_mwr", mem_write_ready, 0);
    @(negedge clk);
    check("load_mwr", mem_write_ready, 1);

    write_row(0, 0, sv00, 2);
    write_row(1, 0, sv10, 3);
    write_row(1, 1, sv11, -1);
    set_params(-50, 0, 1, 2);
    finish_load("load_a");

    run_inf(x0, x1, lat, frp);
    check("a_latency", lat, 5);
    check("a_fin_ready_pattern", frp, 2'b10);
    check("a_labels", labels, 2'b10);
`ifdef SVM_SCORE_OUT_EN
    check("a_score0", scores[31:0], 32'hFFFF_FFE2);
    check("a_score1", scores[63:32], 32'd7);
`endif
    @(negedge clk);
    check("a_dv_drop", dout_valid, 0);
    check("a_fin_ready_back", fin_ready, 1);

    dout_ready = 1'b0;
    run_inf(x0, x1, lat, frp);
    check("bp_latency", lat, 5);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(dout_valid === 1'b1 && labels === 2'b10 && fin_ready === 1'b0)) ok = 1'b0;
    end
    check("bp_hold", ok, 1);
    dout_ready = 1'b1;
    @(negedge clk);
    check("bp_dv_drop", dout_valid, 0);
    check("bp_fin_ready_back", fin_ready, 1);

    write_row(0, 0, rowm, -256);
    run_inf(x0, x1, lat, frp);
    check("ign_latency", lat, 5);
    check("ign_labels", labels, 2'b10);
    @(negedge clk);

    in_features = x0;
    fin_valid   = 1'b1;
    @(negedge clk);
    check("mid_compute_fin_ready", fin_ready, 0);
    rst       = 1'b1;
    fin_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_dv", dout_valid, 0);
    check("mid_rst_fin_ready", fin_ready, 0);
    check("mid_rst_mwr", mem_write_ready, 0);
    check("mid_rst_labels", labels, 0);
    rst = 1'b0;
    check("mid_wait_mwr", mem_write_ready, 0);
    @(negedge clk);
    check("mid_load_mwr", mem_write_ready, 1);
    ok = 1'b1;
    repeat (3) begin
      if (fin_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check("mid_fin_ready_held", ok, 1);

    set_params(0, 0, 0, 2);
    finish_load("load_z");
    run_inf(x0, x1, lat, frp);
    check("z_latency", lat, 5);
    check("z_fin_ready_pattern", frp, 2'b10);
    check("z_labels", labels, 2'b11);
`ifdef SVM_SCORE_OUT_EN
    check("z_score0", scores[31:0], 32'd0);
`endif
    @(negedge clk);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("m_load_mwr", mem_write_ready, 1);
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 3; a++)
        write_row(c, a, rowm, -256);
    set_params(0, 0, 3, 7);
    finish_load("load_m");
    run_inf(rowm, rowm, lat, frp);
    check("m_latency", lat, 8);
    check("m_fin_ready_pattern", frp, 2'b00);
    check("m_labels", labels, 2'b00);
`ifdef SVM_SCORE_OUT_EN
    check("m_score0", scores[31:0], 32'hF400_0000);
    check("m_score1", scores[63:32], 32'hF400_0000);
`endif
    @(negedge clk);
    check("m_dv_drop", dout_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
